// File: rtl/bounce_gen_if.sv
// Request/status bundle between a bounce_gen and whatever drives it.
// The master issues go/target; the slave (bounce_gen) returns the emulated switch and status.
interface bounce_gen_if;
  logic       go;
  logic       target;
  logic       sw;
  logic       busy;
  logic       done_tick;
  logic [7:0] edge_cnt;

  modport master (output go, output target,
                  input  sw, input busy, input done_tick, input edge_cnt);
  modport slave  (input  go, input target,
                  output sw, output busy, output done_tick, output edge_cnt);
endinterface

// File: rtl/bounce_gen.sv
// Synthetic contact-bounce generator: each accepted request moves sw to a new level
// through an LFSR-timed burst of glitches, then holds it through a settle interval.
module bounce_gen #(
  parameter int unsigned BOUNCE_LEN = 1000,
  parameter int unsigned SETTLE_LEN = 500,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  bounce_gen_if.slave  bus
);

  localparam int unsigned CW    = 16;
  localparam int unsigned EW    = 8;
  localparam int unsigned SEGW  = 4;
  localparam logic [CW-1:0] WIN_LOAD    = CW'(BOUNCE_LEN - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BOUNCE, ST_SETTLE} state_t;

  state_t          state_q;
  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_d;
  logic [CW-1:0]   win_q;
  logic [CW-1:0]   settle_q;
  logic [SEGW-1:0] seg_q;
  logic            sw_q;
  logic            tgt_q;
  logic            busy_q;
  logic            done_q;
  logic [EW-1:0]   edge_q;
  logic [EW-1:0]   edge_d;

  // Free-running Fibonacci LFSR, taps 15/13/12/10, shifting left
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Saturating transition count, used wherever a toggle is recorded
  assign edge_d = (edge_q == {EW{1'b1}}) ? edge_q : edge_q + EW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      win_q    <= '0;
      settle_q <= '0;
      seg_q    <= '0;
      sw_q     <= 1'b0;
      tgt_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      edge_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.go && (bus.target != sw_q)) begin
            edge_q  <= '0;
            tgt_q   <= bus.target;
            win_q   <= WIN_LOAD;
            seg_q   <= lfsr_q[SEGW-1:0];
            busy_q  <= 1'b1;
            state_q <= ST_BOUNCE;
          end
        end
        ST_BOUNCE: begin
          // Window expiry wins over a coincident segment expiry
          if (win_q == '0) begin
            sw_q     <= tgt_q;
            if (sw_q != tgt_q) edge_q <= edge_d;
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end else begin
            win_q <= win_q - CW'(1);
            if (seg_q == '0) begin
              sw_q   <= ~sw_q;
              edge_q <= edge_d;
              seg_q  <= lfsr_q[SEGW-1:0];
            end else begin
              seg_q <= seg_q - SEGW'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            settle_q <= settle_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.sw        = sw_q;
  assign bus.busy      = busy_q;
  assign bus.done_tick = done_q;
  assign bus.edge_cnt  = edge_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: a per-request waveform plan built from the LFSR sequence is
// compared against the DUT every cycle, alongside directed timing and reset checks.
module tb_bounce_gen;

  localparam int unsigned BL   = 16;
  localparam int unsigned SL   = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          PLAN = BL + SL + 1;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_err;
  bit   chk_en;

  bounce_gen_if bus ();

  bounce_gen #(.BOUNCE_LEN(BL), .SETTLE_LEN(SL), .SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Expected behaviour: for each accepted request, the complete sw waveform is
  // planned up front from the toggle instants the LFSR dictates.
  logic [15:0] m_lfsr;
  logic        m_sw, m_busy, m_done;
  int          m_edge;
  bit          m_act;
  int          m_r;
  logic        p_sw   [0:PLAN];
  int          p_edge [0:PLAN];

  task automatic build_plan(input logic tgt);
    logic [15:0] lv;
    int          next_t;
    lv        = m_lfsr;
    next_t    = 1 + int'(lv[3:0]);
    p_sw[0]   = m_sw;
    p_sw[1]   = m_sw;
    p_edge[0] = 0;
    p_edge[1] = 0;
    for (int r = 1; r < PLAN; r++) begin
      lv = lfsr_step(lv);
      if (r == BL)      p_sw[r+1] = tgt;
      else if (r > BL)  p_sw[r+1] = p_sw[r];
      else if (r == next_t) begin
        p_sw[r+1] = ~p_sw[r];
        next_t    = r + 1 + int'(lv[3:0]);
      end else          p_sw[r+1] = p_sw[r];
      p_edge[r+1] = p_edge[r] + ((p_sw[r+1] != p_sw[r]) ? 1 : 0);
      if (p_edge[r+1] > 255) p_edge[r+1] = 255;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr = SEED;
      m_act  = 1'b0;
      m_r    = 0;
      m_sw   = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_edge = 0;
    end else begin
      if (!m_busy && bus.go === 1'b1 && bus.target !== m_sw) begin
        build_plan(bus.target);
        m_act = 1'b1;
        m_r   = 1;
      end else if (m_act) begin
        m_r++;
        if (m_r > PLAN) m_act = 1'b0;
      end
      m_lfsr = lfsr_step(m_lfsr);
      if (m_act) begin
        m_sw   = p_sw[m_r];
        m_busy = (m_r <= BL + SL);
        m_done = (m_r == PLAN);
        m_edge = p_edge[m_r];
      end else begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sw",        16'(bus.sw),        16'(m_sw));
      check("busy",      16'(bus.busy),      16'(m_busy));
      check("done_tick", 16'(bus.done_tick), 16'(m_done));
      check("edge_cnt",  16'(bus.edge_cnt),  16'(m_edge));
      if (m_done) check("edge_parity", 16'(bus.edge_cnt[0]), 16'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_go(input logic tgt, output int t0);
    bus.go     = 1'b1;
    bus.target = tgt;
    tick();
    bus.go = 1'b0;
    t0     = cyc;
  endtask

  task automatic wait_done(input int t0, input logic tgt, input bit poke, output bit got);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (poke && k == 4) begin
        bus.go     = 1'b1;
        bus.target = 1'($urandom);
      end
      tick();
      bus.go = 1'b0;
      if (bus.done_tick === 1'b1) begin
        got = 1'b1;
        check("latency", 16'(cyc - t0), 16'(BL + SL));
        check("sw_final", 16'(bus.sw), 16'(tgt));
      end
    end
    if (!got) check("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic abort_pulse();
    #2 reset = 1'b1;
    #1;
    check("abort_sw",   16'(bus.sw),        16'd0);
    check("abort_busy", 16'(bus.busy),      16'd0);
    check("abort_done", 16'(bus.done_tick), 16'd0);
    tick();
    #2 reset = 1'b0;
  endtask

  initial begin
    int t0;
    bit got;
    n_chk      = 0;
    n_err      = 0;
    cyc        = 0;
    chk_en     = 1'b0;
    reset      = 1'b1;
    bus.go     = 1'b0;
    bus.target = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    chk_en = 1'b1;

    // Asynchronous reset between edges takes effect at once
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_sw",   16'(bus.sw),        16'd0);
    check("rst_busy", 16'(bus.busy),      16'd0);
    check("rst_done", 16'(bus.done_tick), 16'd0);
    check("rst_edge", 16'(bus.edge_cnt),  16'd0);
    tick();
    #2 reset = 1'b0;
    tick();
    check("lfsr_pin1", m_lfsr, 16'h59C3);
    tick();
    check("lfsr_pin2", m_lfsr, 16'hB387);

    // Press with a stray go mid-burst, then release chained on the done cycle
    repeat (3) tick();
    do_go(1'b1, t0);
    check("busy_rise", 16'(bus.busy), 16'd1);
    wait_done(t0, 1'b1, 1'b1, got);
    if (got) begin
      do_go(1'b0, t0);
      check("busy_chain", 16'(bus.busy), 16'd1);
      wait_done(t0, 1'b0, 1'b0, got);
    end

    // Request for the current level is ignored
    repeat (2) tick();
    bus.target = m_sw;
    bus.go     = 1'b1;
    tick();
    bus.go = 1'b0;
    check("ignored_busy", 16'(bus.busy), 16'd0);
    repeat (3) tick();

    // Reset mid-burst aborts, then a fresh press completes
    do_go(1'b1, t0);
    repeat (9) tick();
    abort_pulse();
    repeat (30) tick();
    do_go(1'b1, t0);
    wait_done(t0, 1'b1, 1'b0, got);

    // Random requests with occasional aborts, checked every cycle
    for (int i = 0; i < 2000; i++) begin
      bus.go     = ($urandom_range(0, 5) == 0);
      bus.target = 1'($urandom);
      tick();
      bus.go = 1'b0;
      if ($urandom_range(0, 399) == 0) abort_pulse();
    end
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
